branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bpu_pkg.sv | 26 ++
 rtl/branch_predictor.sv | 83 ++++++++
 2 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter encoding
// and its next-state function.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-cycle lookup on the fetch PC,
// registered update from the resolve stage, plus saturating perf counters.
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] fetch_pc_in,
  output logic             prediction_out,
  output logic [WIDTH-1:0] target_out,
  input  logic             update_en_in,
  input  logic [WIDTH-1:0] update_pc_in,
  input  logic             update_taken_in,
  input  logic [WIDTH-1:0] update_target_in,
  input  logic             mispredict_in,
  output logic [31:0]      perf_branches_out,
  output logic [31:0]      perf_mispredicts_out
);

  localparam int unsigned ENTRIES = 1 << INDEX;
  localparam int          TAGW    = WIDTH - INDEX - 2;

  logic             valid_q  [ENTRIES];
  logic [TAGW-1:0]  tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic [INDEX-1:0] fetch_idx;
  logic [TAGW-1:0]  fetch_tag;
  logic             fetch_hit;
  logic [INDEX-1:0] upd_idx;
  logic [TAGW-1:0]  upd_tag;
  logic             upd_hit;
  logic             unused_pc_bits;

  assign fetch_idx = fetch_pc_in[INDEX+1:2];
  assign fetch_tag = fetch_pc_in[WIDTH-1:INDEX+2];
  assign upd_idx   = update_pc_in[INDEX+1:2];
  assign upd_tag   = update_pc_in[WIDTH-1:INDEX+2];

  // Byte offset of the resolved PC plays no part in indexing or tagging.
  assign unused_pc_bits = ^update_pc_in[1:0];

  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup reads the arrays directly, so a same-cycle update is not visible.
  always_comb begin
    prediction_out = fetch_hit & ctr_q[fetch_idx][1];
    target_out     = prediction_out ? target_q[fetch_idx] : fetch_pc_in + WIDTH'(4);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
      perf_branches_out    <= '0;
      perf_mispredicts_out <= '0;
    end else if (update_en_in) begin
      if (perf_branches_out != '1) perf_branches_out <= perf_branches_out + 32'd1;
      if (mispredict_in && (perf_mispredicts_out != '1))
        perf_mispredicts_out <= perf_mispredicts_out + 32'd1;

      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], update_taken_in);
        if (update_taken_in) target_q[upd_idx] <= update_target_in;
      end else if (update_taken_in) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= update_target_in;
        ctr_q[upd_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule
